// File: rtl/frame_sync_gate_pkg.sv
// Shared pixel-pipeline definitions: frame gate state encoding and default geometry.
package frame_sync_gate_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2
  } sync_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_WCNT_WIDTH = 12;
  localparam int unsigned DEF_LCNT_WIDTH = 12;
  localparam int unsigned DEF_MAX_LINES  = 1232;

endpackage

// File: rtl/sync_edge_detect.sv
// Single-stage register on a sync strobe with rise/fall pulses against the live input.
module sync_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Hold the previous-cycle value of the strobe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign q_o    = sig_q;
  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/frame_sync_gate.sv
// Frame gate: forwards only frames seen from their first line, measures
// line count / first-line length and flags geometry errors per frame.
module frame_sync_gate
  import frame_sync_gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned WCNT_WIDTH = DEF_WCNT_WIDTH,
  parameter int unsigned LCNT_WIDTH = DEF_LCNT_WIDTH,
  parameter int unsigned MAX_LINES  = DEF_MAX_LINES
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  line_valid_i,
  input  logic                  frame_active_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  line_valid_o,
  output logic                  frame_valid_o,
  output logic                  frame_start_o,
  output logic                  frame_done_o,
  output logic [LCNT_WIDTH-1:0] line_count_o,
  output logic [WCNT_WIDTH-1:0] line_words_o,
  output logic                  frame_error_o
);

  localparam logic [LCNT_WIDTH-1:0] MAX_L = LCNT_WIDTH'(MAX_LINES);

  sync_state_e state;

  logic fa_q, fa_rise, fa_fall;
  logic lv_q, lv_rise, lv_fall;
  logic unused_edges;

  logic [WCNT_WIDTH-1:0] wcnt;
  logic [LCNT_WIDTH-1:0] lcnt;
  logic [WCNT_WIDTH-1:0] ref_len;
  logic                  run_err;

  logic                  in_active;
  logic [WCNT_WIDTH-1:0] wcnt_next;
  logic [LCNT_WIDTH-1:0] lcnt_next;
  logic [WCNT_WIDTH-1:0] ref_next;
  logic                  err_next;
  logic                  close_line;
  logic                  first_line;
  logic                  over_max;
  logic                  fwd_valid;

  sync_edge_detect u_fa_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (frame_active_i),
    .q_o     (fa_q),
    .rise_o  (fa_rise),
    .fall_o  (fa_fall)
  );

  sync_edge_detect u_lv_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (line_valid_i),
    .q_o     (lv_q),
    .rise_o  (lv_rise),
    .fall_o  (lv_fall)
  );

  assign unused_edges = ^{fa_q, lv_q, lv_rise};

  // Per-cycle counter update; a line still open when the frame ends is closed
  // here too, so the frame-end statistics can be loaded from these values.
  always_comb begin
    in_active  = (state == ST_ACTIVE);
    wcnt_next  = wcnt;
    if (line_valid_i && (wcnt != '1)) begin
      wcnt_next = wcnt + 1'b1;
    end
    close_line = in_active & (lv_fall | (fa_fall & line_valid_i));
    first_line = (lcnt == '0);
    over_max   = (lcnt >= MAX_L);
    lcnt_next  = lcnt;
    if (close_line && (lcnt != '1)) begin
      lcnt_next = lcnt + 1'b1;
    end
    ref_next = ref_len;
    err_next = run_err;
    if (close_line) begin
      if (first_line) begin
        ref_next = wcnt_next;
      end else if (wcnt_next != ref_len) begin
        err_next = 1'b1;
      end
      if (over_max) begin
        err_next = 1'b1;
      end
    end
    fwd_valid = line_valid_i & in_active & ~over_max;
  end

  // Frame FSM with registered outputs, counters and statistics.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_WAIT_LOW;
      data_o        <= '0;
      line_valid_o  <= 1'b0;
      frame_valid_o <= 1'b0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      line_count_o  <= '0;
      line_words_o  <= '0;
      frame_error_o <= 1'b0;
      wcnt          <= '0;
      lcnt          <= '0;
      ref_len       <= '0;
      run_err       <= 1'b0;
    end else begin
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      line_valid_o  <= fwd_valid;
      if (fwd_valid) begin
        data_o <= data_i;
      end
      case (state)
        ST_WAIT_LOW: begin
          if (!frame_active_i) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (fa_rise) begin
            state         <= ST_ACTIVE;
            frame_start_o <= 1'b1;
            frame_valid_o <= 1'b1;
            wcnt          <= '0;
            lcnt          <= '0;
            ref_len       <= '0;
            run_err       <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          wcnt    <= close_line ? '0 : wcnt_next;
          lcnt    <= lcnt_next;
          ref_len <= ref_next;
          run_err <= err_next;
          if (fa_fall) begin
            state         <= ST_IDLE;
            frame_valid_o <= 1'b0;
            frame_done_o  <= 1'b1;
            line_count_o  <= lcnt_next;
            line_words_o  <= ref_next;
            frame_error_o <= err_next;
          end
        end
        default: begin
          state <= ST_WAIT_LOW;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_sync_gate.md
# frame_sync_gate

- Sits directly downstream of the MIPI-to-parallel bridge, on the same pixel clock.
- Consumes the bridge's 32-bit YUV word stream, line-valid and frame-active signals.
- Forwards only frames observed from their first line, and drops partial frames caused by reset or mid-frame start.
- Measures per-frame line count and line length, and flags geometry errors to the downstream USB/host interface logic.

## Interface
- DATA_WIDTH, 32, width of data word.
- WCNT_WIDTH, 12, width of words-per-line counter; saturates at all-ones.
- LCNT_WIDTH, 12, width of line counter; saturates at all-ones.
- MAX_LINES, 1232, lines accepted per frame; later lines are dropped.
- clk_i  in  1  pixel clock; one clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- data_i  in  DATA_WIDTH  word from bridge, valid when line_valid_i=1.
- line_valid_i  in  1  line sync from bridge; high for each word of a line.
- frame_active_i  in  1  frame sync from bridge; high for whole frame.
- data_o  out  DATA_WIDTH  gated word.
- line_valid_o  out  1  gated line valid.
- frame_valid_o  out  1  high while a gated frame is being forwarded.
- frame_start_o  out  1  one-cycle pulse at accepted frame start.
- frame_done_o  out  1  one-cycle pulse when an accepted frame ends.
- line_count_o  out  LCNT_WIDTH  lines in last completed frame; latched at frame_done_o.
- line_words_o  out  WCNT_WIDTH  words in first line of last completed frame.
- frame_error_o  out  1  latched at frame_done_o; set if any line length differed from first line, or lines exceeded MAX_LINES.

## Operation
- Edge detect: frame_active_i and line_valid_i are each registered once. A rise or fall is a change between the registered value and the current input.
- State machine:
  - WAIT_LOW is entered from reset. It moves to IDLE when frame_active_i=0.
  - IDLE moves to ACTIVE on a frame_active_i rise.
  - ACTIVE moves to IDLE on a frame_active_i fall.
- Coming out of reset with frame_active_i=1 stays in WAIT_LOW, so the partial frame is never forwarded.
- On entering ACTIVE:
  - Clear word and line counters, the reference length and the running error.
  - Pulse frame_start_o.
- In ACTIVE, each cycle with line_valid_i=1 increments the word counter (saturating).
- On a line_valid_i fall in ACTIVE:
  - Increment the line counter.
  - On line 1, store the word count as the reference length.
  - On later lines, set the running error if the word count differs from the reference.
  - Clear the word counter.
- Once MAX_LINES lines are complete:
  - Further lines are not forwarded (line_valid_o held 0).
  - The running error is set.
  - Lines keep counting, saturating.
- On a frame_active_i fall in ACTIVE:
  - If line_valid_i is still high, the open line is closed as on a line_valid_i fall.
  - line_count_o, line_words_o and frame_error_o are loaded from that final state.
  - frame_done_o pulses.
- line_valid_i while in IDLE or WAIT_LOW is ignored: not forwarded, not counted.
- A rise and a fall of line_valid_i cannot occur in the same cycle. Back-to-back lines with one low cycle between them must be counted correctly.

## Timing
- Reset values:
  - data_o=0, line_valid_o=0, frame_valid_o=0, frame_start_o=0, frame_done_o=0.
  - line_count_o=0, line_words_o=0, frame_error_o=0.
  - State WAIT_LOW.
- Latency is one cycle: data_o and line_valid_o register data_i and (line_valid_i AND ACTIVE AND under MAX_LINES).
- frame_valid_o:
  - Goes high the cycle after the frame_active_i rise, together with frame_start_o.
  - Goes low the cycle after the fall, together with frame_done_o.
- frame_done_o is asserted in the same cycle as the statistics update.
- data_o holds its last value when line_valid_o=0.
- Reset asserted mid-frame clears all outputs immediately. The remainder of that frame is dropped via WAIT_LOW.

## Structure
- Shared package (with the other pixel-pipeline stages) holds:
  - state enum: WAIT_LOW, IDLE, ACTIVE.
  - default widths and MAX_LINES.
- One sub-module, `sync_edge_detect`: a register plus rise/fall pulses. It is instantiated twice, once for frame_active_i and once for line_valid_i.
- Counters and the FSM stay in the top.

## Test plan
- **Nominal frame:** frame_active_i high; 4 lines of 8 words, 2-cycle gaps; data 0x00000001 upward. Expected:
  - The same 32 words appear with 1-cycle delay.
  - frame_done_o pulses with line_count_o=4, line_words_o=8, frame_error_o=0.
- **Mid-frame reset:** release reset while frame_active_i=1 and lines are running. Expected:
  - No line_valid_o, no frame_start_o until frame_active_i falls and rises again.
  - The next full frame is forwarded normally.
- **Length mismatch:** lines of 8, 8, 7, 8 words. Expected: line_count_o=4, line_words_o=8, frame_error_o=1; the next clean frame returns frame_error_o=0.
- **Overflow:** MAX_LINES=3, send 5 lines. Expected: only 3 lines forwarded, line_count_o=5, frame_error_o=1.
- **Truncated line:** frame_active_i falls while line_valid_i=1 on word 5 of an 8-word line 2. Expected: line_count_o=2, frame_error_o=1, frame_done_o pulses once.
- **Stray line:** line_valid_i pulses while frame_active_i=0. Expected: no output activity, and counters unchanged at the next frame.
